// File: rtl/io_uart_timer_pkg.sv
// Shared constants for the I/O-mapped UART/timer peripheral: register indices,
// STATUS bit positions, bus constants and TX state encodings.
package io_uart_timer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BITCNT_W   = 3;
  localparam int unsigned REG_IDX_W  = 2;

  localparam logic [REG_IDX_W-1:0] REG_TXDATA  = 2'd0;
  localparam logic [REG_IDX_W-1:0] REG_STATUS  = 2'd1;
  localparam logic [REG_IDX_W-1:0] REG_BAUDDIV = 2'd2;
  localparam logic [REG_IDX_W-1:0] REG_TIMER   = 2'd3;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

  localparam logic IO_ENABLE = 1'b1;
  localparam logic IO_WRITE  = 1'b1;
  localparam logic IO_READ   = 1'b0;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Baud counter reload value; a divisor of 0 behaves like 1.
  function automatic logic [DIV_W-1:0] bit_reload(input logic [DIV_W-1:0] div);
    return (div == '0) ? '0 : div - DIV_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Parameterized TX byte FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/io_uart_timer.sv
// I/O-mapped UART transmitter with TX FIFO, baud divisor, STATUS and an
// optional cycle timer enabled by defining IO_UART_TIMER_EN.
module io_uart_timer
  import io_uart_timer_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ioCe,
  input  logic              ioWe,
  input  logic [DATA_W-1:0] ioAddr,
  input  logic [DATA_W-1:0] ioWtData,
  output logic [DATA_W-1:0] ioRdData,
  output logic              txd
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [REG_IDX_W-1:0] reg_idx;
  logic                 bus_wr, bus_rd;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0]    fifo_dout;
  logic [CNT_W-1:0]     fifo_count;

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BITCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 ovf_q, ovf_d;
  logic [DIV_W-1:0]     baud_div_q, baud_div_d;
  logic [DATA_W-1:0]    timer_rd;
  logic [DATA_W-1:0]    status_c;
  logic [DIV_W-1:0]     reload;
  logic                 bit_done;
  logic                 unused_c;

  assign reg_idx   = ioAddr[3:2];
  assign bus_wr    = (ioCe == IO_ENABLE) && (ioWe == IO_WRITE);
  assign bus_rd    = (ioCe == IO_ENABLE) && (ioWe == IO_READ);
  assign fifo_push = bus_wr && (reg_idx == REG_TXDATA);
  assign fifo_pop  = (state_q == TX_IDLE) && !fifo_empty;
  assign unused_c  = ^{ioAddr[DATA_W-1:4], ioAddr[1:0], ioWtData[DATA_W-1:DIV_W]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ioWtData[BYTE_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register writes; an overflow set beats a same-cycle clear.
  always_comb begin
    baud_div_d = baud_div_q;
    ovf_d      = ovf_q;
    if (bus_wr && (reg_idx == REG_BAUDDIV)) begin
      baud_div_d = ioWtData[DIV_W-1:0];
    end
    if (bus_wr && (reg_idx == REG_STATUS) && ioWtData[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  assign reload   = bit_reload(baud_div_q);
  assign bit_done = (baud_cnt_q == '0);

  // TX FSM; the divisor is sampled only at bit boundaries.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          shift_d    = fifo_dout;
          bit_cnt_d  = '0;
          baud_cnt_d = reload;
          txd_d      = 1'b0;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          txd_d      = shift_q[0];
          shift_d    = shift_q >> 1;
          bit_cnt_d  = '0;
          baud_cnt_d = reload;
          state_d    = TX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          baud_cnt_d = reload;
          if (bit_cnt_q == BITCNT_W'(7)) begin
            txd_d   = 1'b1;
            state_d = TX_STOP;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          txd_d   = 1'b1;
          state_d = TX_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      ovf_q      <= 1'b0;
      baud_div_q <= DIV_RESET;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      ovf_q      <= ovf_d;
      baud_div_q <= baud_div_d;
    end
  end

`ifdef IO_UART_TIMER_EN
  logic [DATA_W-1:0] timer_q, timer_d;

  // A write loads the counter and holds it for one cycle before counting resumes.
  always_comb begin
    timer_d = timer_q + DATA_W'(1);
    if (bus_wr && (reg_idx == REG_TIMER)) begin
      timer_d = ioWtData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    status_c                              = '0;
    status_c[ST_FULL]                     = fifo_full;
    status_c[ST_EMPTY]                    = fifo_empty;
    status_c[ST_BUSY]                     = (state_q != TX_IDLE);
    status_c[ST_OVF]                      = ovf_q;
    status_c[ST_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(fifo_count);
  end

  // Zero-latency read mux; idle or write cycles return 0.
  always_comb begin
    ioRdData = '0;
    if (bus_rd) begin
      case (reg_idx)
        REG_STATUS:  ioRdData = status_c;
        REG_BAUDDIV: ioRdData = DATA_W'(baud_div_q);
        REG_TIMER:   ioRdData = timer_rd;
        default:     ioRdData = '0;
      endcase
    end
  end

  assign txd = txd_q;

endmodule

// File: doc/io_uart_timer.md
# io_uart_timer

Memory-mapped I/O peripheral on the I/O side of the memory/IO controller: consumes its `ioCe/ioWe/ioAddr/ioWtData` bus for the 0x7xxx_xxxx region and returns `ioRdData`. It provides a UART transmitter with a small TX FIFO, a programmable baud divisor, a status register and an optional free-running cycle timer. Reads are combinational, so the CPU's MEM stage sees data in the same cycle as the access; writes take effect at the clock edge.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries; a power of 2, at least 2.
- `DIV_RESET`, 16'd434: reset value of BAUDDIV, in clock cycles per bit.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `ioCe`  in  1  I/O chip enable, active-high.
- `ioWe`  in  1  1 = write, 0 = read; ignored when `ioCe` = 0.
- `ioAddr`  in  32  byte address; only bits [3:2] are decoded.
- `ioWtData`  in  32  write data.
- `ioRdData`  out  32  read data; combinational from `ioCe`, `ioAddr` and register state.
- `txd`  out  1  UART serial output; idles high; registered.

## Operation
- Register map by `ioAddr[3:2]`; all other address bits are ignored and alias.
  - 0 TXDATA (write-only; reads 0): a write pushes `ioWtData[7:0]` into the FIFO.
  - 1 STATUS (R/W). Bit0 full, bit1 empty, bit2 busy (state ≠ IDLE), bit3 overflow (sticky), bits[7:4] FIFO count, rest 0. Writing 1 to bit3 clears overflow; all other written bits are ignored.
  - 2 BAUDDIV (R/W): 16 bits, read zero-extended. The bit period is BAUDDIV cycles; a value of 0 is treated as 1.
  - 3 TIMER: see Configuration.
- `ioRdData` is 0 whenever `ioCe` = 0 or `ioWe` = 1. Reads have no side effects.
- FIFO push when full:
  - If no pop occurs that cycle, the byte is dropped and overflow is set.
  - If a pop occurs the same cycle, the push is accepted and the count is unchanged.
- Overflow set and clear in the same cycle: set wins.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: `txd` = 1. If the FIFO is non-empty, pop the head into the shift register, load the bit counter, go to START.
  - START: `txd` = 0 for one bit period, then go to DATA.
  - DATA: 8 bits, LSB first, one bit period each, then go to STOP.
  - STOP: `txd` = 1 for one bit period, then go to IDLE.
  - IDLE always lasts at least one cycle between frames.
- Baud counter:
  - Reloads to max(BAUDDIV,1)−1 at each bit start and counts down; the bit ends when it reaches 0.
  - A BAUDDIV write mid-frame takes effect at the next bit boundary.
- Reset values: `txd` = 1, state IDLE, FIFO empty (read/write pointers 0), overflow 0, BAUDDIV = `DIV_RESET`, TIMER 0. `ioRdData` follows these values combinationally.
- Reset mid-frame aborts the frame: `txd` returns high at the reset edge and the FIFO contents are discarded.

## Timing
- TXDATA write at edge N: the count shows 1 after N; the pop happens at edge N+1; `txd` falls after edge N+1.
- Frame length is 10 × max(BAUDDIV,1) cycles, plus at least 1 IDLE cycle before the next frame.
- Register writes are visible to a read in the cycle after the write edge.
- Read latency is 0 cycles.

## Configuration
- `IO_UART_TIMER_EN` defined:
  - TIMER is a 32-bit counter that increments every cycle and wraps from 0xFFFF_FFFF to 0.
  - A write loads `ioWtData`; the next cycle reads the written value, and counting resumes after that.
  - Reads return the current value.
- Not defined: TIMER reads 0, writes are ignored, and no counter flops are synthesized.

## Structure
- The shared define header (`define.v`) holds:
  - register offsets (TXDATA/STATUS/BAUDDIV/TIMER indices);
  - TX state encodings;
  - STATUS bit positions;
  - the existing enable/write constants.
- Sub-module `uart_tx_fifo`: parameterized FIFO with push, pop, din, dout, full, empty and count outputs. Its push-when-full-with-pop rule matches Operation.
- Top level holds register decode, the TX FSM, the baud counter and the timer.

## Test plan
- Reset, then read STATUS -> 0x0000_0002; BAUDDIV -> 434; `txd` = 1.
- Set BAUDDIV = 4, write TXDATA 0xA5 -> after 1 cycle `txd` = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4; busy clears 40 cycles after start.
- BAUDDIV = 4, write 6 bytes back-to-back -> 5 accepted (4 in FIFO + 1 popped); the 6th is dropped and STATUS bit3 = 1. Writing STATUS 0x8 clears it.
- Write TXDATA at the same edge the FSM pops from a full FIFO -> accepted, count stays 4, no overflow.
- With `IO_UART_TIMER_EN`: write TIMER 0xFFFF_FFFE, read over the next 3 cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. Without it: reads 0.
- Assert `rst` in the middle of DATA -> `txd` = 1 and STATUS = 0x2 after the edge; the next frame starts cleanly.
